// File: rtl/ip_seq_pkg.sv
// Shared types and width constants for the FC inner-product sequencer.
// Optional perf counters are enabled with the IP_PERF_CNT_EN macro in ip_seq_ctrl.
package ip_seq_pkg;

  localparam int unsigned LAYER_MAX = 8;
  localparam int unsigned INN_W     = 16;
  localparam int unsigned ONN_W     = 14;
  localparam int unsigned BATCH_W   = 8;
  localparam int unsigned NBUF      = 2;
  localparam int unsigned LW        = $clog2(LAYER_MAX);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LAYER_START = 3'd1,
    ONEUR_PROC  = 3'd2,
    ONEUR_DRAIN = 3'd3,
    ONEUR_WRIT  = 3'd4,
    LAYER_DONE  = 3'd5,
    IP_DONE     = 3'd6
  } ip_state_e;

  typedef struct packed {
    logic [INN_W-1:0] inn;
    logic [ONN_W-1:0] onn;
    logic             relu;
  } ip_entry_t;

endpackage

// File: rtl/ip_prefetch_ctrl.sv
// DDR parameter prefetch: one-cycle read kick plus an arbiter request held
// until the buffer fill completes.
module ip_prefetch_ctrl
  import ip_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic wr_ddr_done_i,
  input  logic all_full_i,
  input  logic wr_buf_done_i,
  output logic rd_ddr_en_o,
  output logic arbitor_rd_en_o
);

  logic seen_q, seen_d;
  logic arb_q, arb_d;
  logic kick_q, kick_d;
  logic req_c;

  // A completing burst always clears the hold; a new request waits a cycle.
  always_comb begin
    seen_d = en_i & (seen_q | wr_ddr_done_i);
    req_c  = en_i & seen_q & ~all_full_i & ~arb_q;
    arb_d  = arb_q;
    kick_d = 1'b0;
    if (!en_i || wr_buf_done_i) begin
      arb_d = 1'b0;
    end else if (req_c) begin
      arb_d  = 1'b1;
      kick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seen_q <= 1'b0;
      arb_q  <= 1'b0;
      kick_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
      arb_q  <= arb_d;
      kick_q <= kick_d;
    end
  end

  assign rd_ddr_en_o     = kick_q;
  assign arbitor_rd_en_o = arb_q;

endmodule

// File: rtl/ip_seq_ctrl.sv
// FC inner-product sequencer walking a runtime-programmed layer table.
// Define IP_PERF_CNT_EN to add stall_cyc_o / busy_cyc_o cycle counters.
module ip_seq_ctrl
  import ip_seq_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cfg_we_i,
  input  logic [LW-1:0]      cfg_idx_i,
  input  logic [INN_W-1:0]   cfg_inn_i,
  input  logic [ONN_W-1:0]   cfg_onn_i,
  input  logic               cfg_relu_i,
  input  logic [LW:0]        cfg_nlayer_i,
  input  logic [BATCH_W-1:0] cfg_batch_i,
  input  logic               ip_en_i,
  input  logic [NBUF-1:0]    param_buf_full_i,
  input  logic               rd_bram_en_i,
  input  logic               rd_buf_done_i,
  input  logic               output_en_i,
  input  logic               wr_ddr_done_i,
  input  logic               wr_buf_done_i,
  input  logic               exp_done_i,
  output logic               rd_buf_en_o,
  output logic               rd_bram_start_o,
  output logic               rd_ddr_en_o,
  output logic               arbitor_rd_en_o,
  output logic [LW-1:0]      cur_layer_o,
  output logic [INN_W-1:0]   inn_o,
  output logic [ONN_W-1:0]   onn_o,
  output logic               relu_en_o,
  output logic               oneuron_start_o,
  output logic               oneuron_done_o,
  output logic               layer_done_o,
  output logic               ip_done_o,
  output logic               img_done_o,
  output logic               batch_done_o,
  output logic               ip_proc_o,
  output logic               conv_buf_free_o
`ifdef IP_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cyc_o,
  output logic [31:0]        busy_cyc_o
`endif
);

  ip_state_e          state_q, state_d;
  ip_entry_t          tbl_q [LAYER_MAX];
  ip_entry_t          tbl_d [LAYER_MAX];
  ip_entry_t          ent_q, ent_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [LW:0]        nlayer_q, nlayer_d;
  logic [BATCH_W-1:0] batch_q, batch_d, bcnt_q, bcnt_d;
  logic [INN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [ONN_W-1:0]   out_cnt_q, out_cnt_d;
  logic               last_q, last_d;
  logic               ostart_q, ostart_d, odone_q, odone_d, ldone_q, ldone_d;
  logic               ipdone_q, ipdone_d, imgdone_q, imgdone_d, bdone_q, bdone_d;
  logic               proc_q, proc_d, free_q, free_d;
  logic               any_full_c, rd_en_c, final_in_c, last_out_c;

  assign any_full_c = |param_buf_full_i;
  assign final_in_c = rd_bram_en_i && (in_cnt_q == INN_W'(ent_q.inn - 1'b1));
  assign last_out_c = (out_cnt_q == ONN_W'(ent_q.onn - 1'b1));

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    ent_d     = ent_q;
    layer_d   = layer_q;
    nlayer_d  = nlayer_q;
    batch_d   = batch_q;
    bcnt_d    = bcnt_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    last_d    = last_q;
    free_d    = free_q;
    ostart_d  = 1'b0;
    odone_d   = 1'b0;
    ldone_d   = 1'b0;
    ipdone_d  = 1'b0;
    imgdone_d = 1'b0;
    bdone_d   = 1'b0;
    rd_en_c   = 1'b0;
    if (cfg_we_i && !proc_q) begin
      tbl_d[cfg_idx_i] = '{inn: cfg_inn_i, onn: cfg_onn_i, relu: cfg_relu_i};
    end
    unique case (state_q)
      IDLE: if (ip_en_i) begin
        nlayer_d = cfg_nlayer_i;
        batch_d  = (cfg_batch_i == '0) ? BATCH_W'(1) : cfg_batch_i;
        layer_d  = '0;
        ent_d    = tbl_q[0];
        free_d   = 1'b0;
        if (cfg_nlayer_i == '0) begin
          state_d  = IP_DONE;
          ipdone_d = 1'b1;
          free_d   = 1'b1;
        end else begin
          state_d = LAYER_START;
        end
      end
      LAYER_START: begin
        out_cnt_d = '0;
        if (ent_q.inn == '0 || ent_q.onn == '0) begin
          state_d = LAYER_DONE;
          ldone_d = 1'b1;
        end else if (any_full_c) begin
          state_d  = ONEUR_PROC;
          ostart_d = 1'b1;
          in_cnt_d = '0;
          last_d   = 1'b0;
        end
      end
      // Read enable falls in the same cycle as the final input or a stall cause.
      ONEUR_PROC: begin
        if (!last_q) begin
          rd_en_c = any_full_c && !rd_buf_done_i && !final_in_c;
          if (final_in_c) begin
            in_cnt_d = '0;
            last_d   = 1'b1;
          end else if (rd_bram_en_i) begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end else if (!rd_buf_done_i) begin
          state_d = ONEUR_DRAIN;
          odone_d = 1'b1;
        end
      end
      ONEUR_DRAIN: if (output_en_i) state_d = ONEUR_WRIT;
      ONEUR_WRIT: begin
        if (last_out_c) begin
          state_d = LAYER_DONE;
          ldone_d = 1'b1;
        end else if (any_full_c && !rd_buf_done_i) begin
          state_d   = ONEUR_PROC;
          ostart_d  = 1'b1;
          in_cnt_d  = '0;
          last_d    = 1'b0;
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end
      LAYER_DONE: begin
        if ({1'b0, layer_q} == (LW+1)'(nlayer_q - 1'b1)) begin
          state_d  = IP_DONE;
          ipdone_d = 1'b1;
          free_d   = 1'b1;
        end else begin
          state_d = LAYER_START;
          layer_d = layer_q + 1'b1;
          ent_d   = tbl_q[LW'(layer_q + 1'b1)];
        end
      end
      IP_DONE: if (exp_done_i) begin
        state_d   = IDLE;
        imgdone_d = 1'b1;
        if (bcnt_q == BATCH_W'(batch_q - 1'b1)) begin
          bcnt_d  = '0;
          bdone_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    proc_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      for (int i = 0; i < LAYER_MAX; i++) tbl_q[i] <= '0;
      ent_q     <= '0;
      layer_q   <= '0;
      nlayer_q  <= '0;
      batch_q   <= '0;
      bcnt_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      last_q    <= 1'b0;
      ostart_q  <= 1'b0;
      odone_q   <= 1'b0;
      ldone_q   <= 1'b0;
      ipdone_q  <= 1'b0;
      imgdone_q <= 1'b0;
      bdone_q   <= 1'b0;
      proc_q    <= 1'b0;
      free_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tbl_q     <= tbl_d;
      ent_q     <= ent_d;
      layer_q   <= layer_d;
      nlayer_q  <= nlayer_d;
      batch_q   <= batch_d;
      bcnt_q    <= bcnt_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      last_q    <= last_d;
      ostart_q  <= ostart_d;
      odone_q   <= odone_d;
      ldone_q   <= ldone_d;
      ipdone_q  <= ipdone_d;
      imgdone_q <= imgdone_d;
      bdone_q   <= bdone_d;
      proc_q    <= proc_d;
      free_q    <= free_d;
    end
  end

  ip_prefetch_ctrl u_prefetch (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .en_i           (proc_q),
    .wr_ddr_done_i  (wr_ddr_done_i),
    .all_full_i     (&param_buf_full_i),
    .wr_buf_done_i  (wr_buf_done_i),
    .rd_ddr_en_o    (rd_ddr_en_o),
    .arbitor_rd_en_o(arbitor_rd_en_o)
  );

`ifdef IP_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, busy_cnt_q, busy_cnt_d;
  logic        stall_c;

  // Parameter stalls: a neuron could start but no buffer is ready.
  assign stall_c = (state_q == LAYER_START && ent_q.inn != '0 && ent_q.onn != '0 && !any_full_c) ||
                   (state_q == ONEUR_WRIT && !last_out_c && !(any_full_c && !rd_buf_done_i));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    if (state_q == IDLE && ip_en_i) begin
      stall_cnt_d = '0;
      busy_cnt_d  = '0;
    end else begin
      if (stall_c && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (proc_q && busy_cnt_q != '1)   busy_cnt_d  = busy_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign stall_cyc_o = stall_cnt_q;
  assign busy_cyc_o  = busy_cnt_q;
`endif

  assign rd_buf_en_o     = rd_en_c;
  assign rd_bram_start_o = rd_en_c;
  assign cur_layer_o     = layer_q;
  assign inn_o           = ent_q.inn;
  assign onn_o           = ent_q.onn;
  assign relu_en_o       = ent_q.relu;
  assign oneuron_start_o = ostart_q;
  assign oneuron_done_o  = odone_q;
  assign layer_done_o    = ldone_q;
  assign ip_done_o       = ipdone_q;
  assign img_done_o      = imgdone_q;
  assign batch_done_o    = bdone_q;
  assign ip_proc_o       = proc_q;
  assign conv_buf_free_o = free_q;

endmodule

// File: tb/tb_ip_seq_ctrl.sv
// Directed self-checking bench for ip_seq_ctrl.
module tb_ip_seq_ctrl;
  import ip_seq_pkg::*;

  logic clk = 1'b0;
  logic rstn_i;
  logic cfg_we_i, cfg_relu_i, ip_en_i, rd_bram_en_i, rd_buf_done_i, output_en_i;
  logic wr_ddr_done_i, wr_buf_done_i, exp_done_i;
  logic [LW-1:0] cfg_idx_i;
  logic [INN_W-1:0] cfg_inn_i;
  logic [ONN_W-1:0] cfg_onn_i;
  logic [LW:0] cfg_nlayer_i;
  logic [BATCH_W-1:0] cfg_batch_i;
  logic [NBUF-1:0] param_buf_full_i;
  logic rd_buf_en_o, rd_bram_start_o, rd_ddr_en_o, arbitor_rd_en_o, relu_en_o;
  logic [LW-1:0] cur_layer_o;
  logic [INN_W-1:0] inn_o;
  logic [ONN_W-1:0] onn_o;
  logic oneuron_start_o, oneuron_done_o, layer_done_o, ip_done_o, img_done_o, batch_done_o;
  logic ip_proc_o, conv_buf_free_o;
`ifdef IP_PERF_CNT_EN
  logic [31:0] stall_cyc_o, busy_cyc_o;
`endif

  always #5 clk = ~clk;

  ip_seq_ctrl dut (
    .clk_i(clk), .rstn_i(rstn_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_inn_i(cfg_inn_i), .cfg_onn_i(cfg_onn_i), .cfg_relu_i(cfg_relu_i),
    .cfg_nlayer_i(cfg_nlayer_i), .cfg_batch_i(cfg_batch_i), .ip_en_i(ip_en_i),
    .param_buf_full_i(param_buf_full_i), .rd_bram_en_i(rd_bram_en_i),
    .rd_buf_done_i(rd_buf_done_i), .output_en_i(output_en_i),
    .wr_ddr_done_i(wr_ddr_done_i), .wr_buf_done_i(wr_buf_done_i), .exp_done_i(exp_done_i),
    .rd_buf_en_o(rd_buf_en_o), .rd_bram_start_o(rd_bram_start_o), .rd_ddr_en_o(rd_ddr_en_o),
    .arbitor_rd_en_o(arbitor_rd_en_o), .cur_layer_o(cur_layer_o), .inn_o(inn_o),
    .onn_o(onn_o), .relu_en_o(relu_en_o), .oneuron_start_o(oneuron_start_o),
    .oneuron_done_o(oneuron_done_o), .layer_done_o(layer_done_o), .ip_done_o(ip_done_o),
    .img_done_o(img_done_o), .batch_done_o(batch_done_o), .ip_proc_o(ip_proc_o),
    .conv_buf_free_o(conv_buf_free_o)
`ifdef IP_PERF_CNT_EN
    , .stall_cyc_o(stall_cyc_o), .busy_cyc_o(busy_cyc_o)
`endif
  );

  int n_chk = 0, n_pass = 0;
  int n_start, n_done, n_ldone, n_ipdone, n_img, n_bdone, n_st_l1, consumed, nc;
  int drop_left, timeouts = 0, first_inn;
  logic [7:0] relu_hist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cfg_write(input int idx, input int inn, input int onn, input bit relu);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_idx_i = LW'(idx); cfg_inn_i = INN_W'(inn);
    cfg_onn_i = ONN_W'(onn); cfg_relu_i = relu;
    @(posedge clk); #1 cfg_we_i = 1'b0;
  endtask

  // Acts as the datapath and export stage for one image; tallies DUT pulses.
  task automatic run_image(input bit drop_en, input bit busy_wr);
    bit fin = 1'b0, drop_done = 1'b0;
    n_start = 0; n_done = 0; n_ldone = 0; n_ipdone = 0; n_img = 0; n_bdone = 0;
    n_st_l1 = 0; consumed = 0; nc = 0; drop_left = 0; first_inn = -1; relu_hist = '0;
    ip_en_i = 1'b1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      ip_en_i = 0; cfg_we_i = 0; rd_bram_en_i = 0; output_en_i = 0; exp_done_i = 0;
      @(negedge clk);
      if (oneuron_start_o) begin
        n_start++; nc = 0; relu_hist = {relu_hist[6:0], relu_en_o};
        if (cur_layer_o == LW'(1)) n_st_l1++;
        if (n_start == 1) first_inn = int'(inn_o);
      end
      if (oneuron_done_o) begin n_done++; output_en_i = 1'b1; end
      if (layer_done_o) n_ldone++;
      if (ip_done_o) begin n_ipdone++; exp_done_i = 1'b1; end
      if (batch_done_o) n_bdone++;
      if (img_done_o) begin n_img++; fin = 1'b1; end
      if (drop_left > 0) begin
        chk("drop_rd_buf_en", 32'(rd_buf_en_o), 32'd0);
        drop_left--;
        if (drop_left == 0) param_buf_full_i = 2'b11;
      end else if (rd_buf_en_o) begin
        if (drop_en && !drop_done && nc == 2) begin
          drop_done = 1'b1; drop_left = 5; param_buf_full_i = 2'b00;
        end else begin
          rd_bram_en_i = 1'b1; consumed++; nc++;
        end
      end
      if (busy_wr && cyc == 3) begin
        cfg_we_i = 1'b1; cfg_idx_i = '0; cfg_inn_i = 9; cfg_onn_i = 9; cfg_relu_i = 1'b0;
      end
    end
    if (!fin) timeouts++;
  endtask

  initial begin
    bit got;
    rstn_i = 0; cfg_we_i = 0; cfg_relu_i = 0; ip_en_i = 0; rd_bram_en_i = 0;
    rd_buf_done_i = 0; output_en_i = 0; wr_ddr_done_i = 0; wr_buf_done_i = 0; exp_done_i = 0;
    cfg_idx_i = '0; cfg_inn_i = '0; cfg_onn_i = '0; cfg_nlayer_i = '0; cfg_batch_i = '0;
    param_buf_full_i = '0;
    @(negedge clk);
    chk("rst_ip_proc", 32'(ip_proc_o), 0);
    chk("rst_conv_free", 32'(conv_buf_free_o), 1);
    chk("rst_rd_buf_en", 32'(rd_buf_en_o), 0);
    chk("rst_rd_ddr_en", 32'(rd_ddr_en_o), 0);
    chk("rst_arbitor", 32'(arbitor_rd_en_o), 0);
    chk("rst_inn", 32'(inn_o), 0);
    chk("rst_layer", 32'(cur_layer_o), 0);
    @(negedge clk); rstn_i = 1;

    // Two-layer image with a busy-time table write that must be ignored.
    cfg_write(0, 4, 3, 1'b1);
    cfg_write(1, 3, 2, 1'b0);
    cfg_nlayer_i = 2; cfg_batch_i = 0; param_buf_full_i = 2'b11;
    run_image(1'b0, 1'b1);
    chk("full_starts", 32'(n_start), 5);
    chk("full_dones", 32'(n_done), 5);
    chk("full_layer_done", 32'(n_ldone), 2);
    chk("full_ip_done", 32'(n_ipdone), 1);
    chk("full_img_done", 32'(n_img), 1);
    chk("full_batch_done", 32'(n_bdone), 1);
    chk("full_relu_hist", 32'(relu_hist), 32'b11100);
    chk("full_l1_starts", 32'(n_st_l1), 2);
    chk("full_inputs", 32'(consumed), 18);
    chk("full_idle_proc", 32'(ip_proc_o), 0);
    chk("full_idle_free", 32'(conv_buf_free_o), 1);

    // Buffer-full drop for 5 cycles mid-neuron.
    run_image(1'b1, 1'b0);
    chk("drop_inputs", 32'(consumed), 18);
    chk("drop_starts", 32'(n_start), 5);
    chk("drop_dones", 32'(n_done), 5);
    chk("busy_write_ignored", 32'(first_inn), 4);

    // Batch of three, then the first image of the next batch.
    cfg_batch_i = 3;
    run_image(1'b0, 1'b0);
    chk("b1_img", 32'(n_img), 1);
    chk("b1_batch_done", 32'(n_bdone), 0);
    run_image(1'b0, 1'b0);
    chk("b2_batch_done", 32'(n_bdone), 0);
    run_image(1'b0, 1'b0);
    chk("b3_img", 32'(n_img), 1);
    chk("b3_batch_done", 32'(n_bdone), 1);
    run_image(1'b0, 1'b0);
    chk("b4_batch_done", 32'(n_bdone), 0);
    cfg_batch_i = 0;

    // Layer 1 skipped via onn=0.
    cfg_write(1, 3, 0, 1'b0);
    run_image(1'b0, 1'b0);
    chk("skip_starts", 32'(n_start), 3);
    chk("skip_l1_starts", 32'(n_st_l1), 0);
    chk("skip_layer_done", 32'(n_ldone), 2);
    chk("skip_ip_done", 32'(n_ipdone), 1);

    // Zero active layers.
    cfg_nlayer_i = 0;
    run_image(1'b0, 1'b0);
    chk("nl0_layer_done", 32'(n_ldone), 0);
    chk("nl0_ip_done", 32'(n_ipdone), 1);
    chk("nl0_img_done", 32'(n_img), 1);
    cfg_nlayer_i = 2;
    chk("no_timeouts", 32'(timeouts), 0);

    // Prefetch: stall in LAYER_START with empty buffers.
    @(negedge clk);
    param_buf_full_i = 2'b00; wr_ddr_done_i = 1; ip_en_i = 1;
    @(posedge clk); #1 ip_en_i = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ddr_en_o) got = 1;
    end
    chk("pf_kick_seen", 32'(got), 1);
    chk("pf_arb_with_kick", 32'(arbitor_rd_en_o), 1);
    chk("pf_busy", 32'(ip_proc_o), 1);
    chk("pf_conv_not_free", 32'(conv_buf_free_o), 0);
    @(negedge clk);
    chk("pf_kick_one_cycle", 32'(rd_ddr_en_o), 0);
    chk("pf_arb_held", 32'(arbitor_rd_en_o), 1);
    wr_buf_done_i = 1;
    @(posedge clk); #1 wr_buf_done_i = 0;
    @(negedge clk);
    chk("pf_arb_dropped", 32'(arbitor_rd_en_o), 0);
    chk("pf_no_kick_on_clear", 32'(rd_ddr_en_o), 0);
    @(negedge clk);
    chk("pf_rekick", 32'(rd_ddr_en_o), 1);
    chk("pf_arb_again", 32'(arbitor_rd_en_o), 1);

    // Reset in ONEUR_PROC, then confirm the table was cleared.
    @(negedge clk); rstn_i = 0; wr_ddr_done_i = 0;
    @(negedge clk); rstn_i = 1;
    cfg_write(0, 4, 3, 1'b1);
    cfg_write(1, 3, 2, 1'b0);
    param_buf_full_i = 2'b11;
    @(negedge clk); ip_en_i = 1;
    @(posedge clk); #1 ip_en_i = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_buf_en_o) got = 1;
    end
    chk("rm_reached_proc", 32'(got), 1);
    rstn_i = 0;
    @(posedge clk); #1;
    chk("rm_ip_proc", 32'(ip_proc_o), 0);
    chk("rm_conv_free", 32'(conv_buf_free_o), 1);
    chk("rm_rd_buf_en", 32'(rd_buf_en_o), 0);
    chk("rm_inn", 32'(inn_o), 0);
    chk("rm_onn", 32'(onn_o), 0);
    @(negedge clk); rstn_i = 1;
    run_image(1'b0, 1'b0);
    chk("rm_tbl_clear_starts", 32'(n_start), 0);
    chk("rm_tbl_clear_ldone", 32'(n_ldone), 2);
    chk("rm_tbl_clear_img", 32'(n_img), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
